inst_cache: RTL and testbench

Direct-mapped instruction cache between the fetch stage and the instruction memory. It serves 32-bit instruction fetches from up to NUM_LINES cached 8-word (32-byte) lines. On a miss it requests the whole aligned line from instruction memory and holds the address stable until the 8-word block returns with its valid strobe. It then installs the line and returns the requested word.

---
 rtl/icache_pkg.sv | 22 ++
 rtl/icache_line_store.sv | 65 ++++++
 rtl/inst_cache.sv | 140 ++++++++++++++
 tb/tb_inst_cache.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
// Line geometry constants, the controller state type, and helpers
// that split a byte address into line index and tag for a given
// number of lines.
package icache_pkg;

  localparam int LINE_WORDS = 8;
  localparam int OFFSET_W   = 5;
  localparam int WORD_OFF_W = 3;

  typedef enum logic [1:0] {LOOKUP, REQ, WAIT, RESP} state_e;

  // Results are 64 bits wide; callers cast down to the exact index/tag width.
  function automatic logic [63:0] line_index(input logic [63:0] addr, input int num_lines);
    return (addr >> OFFSET_W) & 64'(num_lines - 1);
  endfunction

  function automatic logic [63:0] line_tag(input logic [63:0] addr, input int num_lines);
    return addr >> (OFFSET_W + $clog2(num_lines));
  endfunction

endpackage

// File: rtl/icache_line_store.sv
// Valid/tag/data storage for the instruction cache.
// Ports:
//   i_clk, i_rst          clock, async active-high reset (clears valid bits only)
//   i_flush               clear every valid bit on the next edge
//   i_rd_addr             lookup address -> o_hit, o_rd_word (combinational)
//   i_wr_en, i_wr_addr    install a full line at the index of i_wr_addr
//   i_wr_line             the 8 words of that line, word 0 in element 0
module icache_line_store
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 32
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_flush,
  input  logic [ADDR_W-1:0]            i_rd_addr,
  output logic                         o_hit,
  output logic [31:0]                  o_rd_word,
  input  logic                         i_wr_en,
  input  logic [ADDR_W-1:0]            i_wr_addr,
  input  logic [LINE_WORDS-1:0][31:0]  i_wr_line
);

  localparam int IDX_W = $clog2(NUM_LINES);
  localparam int TAG_W = ADDR_W - OFFSET_W - IDX_W;

  logic [NUM_LINES-1:0]            r_valid;
  logic [TAG_W-1:0]                r_tag  [NUM_LINES];
  logic [LINE_WORDS-1:0][31:0]     r_data [NUM_LINES];

  logic [IDX_W-1:0]      w_rd_idx;
  logic [TAG_W-1:0]      w_rd_tag;
  logic [WORD_OFF_W-1:0] w_rd_off;
  logic [IDX_W-1:0]      w_wr_idx;
  logic [TAG_W-1:0]      w_wr_tag;

  assign w_rd_idx = IDX_W'(line_index(64'(i_rd_addr), NUM_LINES));
  assign w_rd_tag = TAG_W'(line_tag(64'(i_rd_addr), NUM_LINES));
  assign w_rd_off = i_rd_addr[OFFSET_W-1:2];
  assign w_wr_idx = IDX_W'(line_index(64'(i_wr_addr), NUM_LINES));
  assign w_wr_tag = TAG_W'(line_tag(64'(i_wr_addr), NUM_LINES));

  assign o_hit     = r_valid[w_rd_idx] && (r_tag[w_rd_idx] == w_rd_tag);
  assign o_rd_word = r_data[w_rd_idx][w_rd_off];

  // A fill landing on the same edge as a flush still leaves its line valid:
  // the write is the later assignment and wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_valid <= '0;
    end else begin
      if (i_flush) r_valid <= '0;
      if (i_wr_en) r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_tag[w_wr_idx]  <= w_wr_tag;
      r_data[w_wr_idx] <= i_wr_line;
    end
  end

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache between fetch and instruction memory.
// Hits return one cycle after the request; misses fetch the whole
// aligned 8-word line, install it, then return the requested word.
// Ports:
//   i_clk, i_start              clock, async active-high reset
//   i_fetch_req/i_fetch_addr    fetch request (addr bits [1:0] ignored)
//   o_fetch_instr/o_fetch_rdy   returned word and its one-cycle strobe
//   o_stall                     busy; requests are ignored while high
//   i_flush                     invalidate all lines
//   o_mem_read/o_mem_addr       line read request, line-aligned address
//   i_mem_instr_0..7/i_mem_valid returned line and its strobe
//   o_hit_count/o_miss_count    saturating performance counters
//
// state  | meaning
// LOOKUP | idle / serving hits; a miss latches the address
// REQ    | mem_read pulse for the missing line
// WAIT   | holding mem_addr until the line comes back
// RESP   | fetch_rdy for the missed word, no lookup this cycle
module inst_cache
  import icache_pkg::*;
#(
  parameter int NUM_LINES = 4,
  parameter int ADDR_W    = 32
) (
  input  logic              i_clk,
  input  logic              i_start,
  input  logic              i_fetch_req,
  input  logic [ADDR_W-1:0] i_fetch_addr,
  output logic [31:0]       o_fetch_instr,
  output logic              o_fetch_rdy,
  output logic              o_stall,
  input  logic              i_flush,
  output logic              o_mem_read,
  output logic [ADDR_W-1:0] o_mem_addr,
  input  logic [31:0]       i_mem_instr_0,
  input  logic [31:0]       i_mem_instr_1,
  input  logic [31:0]       i_mem_instr_2,
  input  logic [31:0]       i_mem_instr_3,
  input  logic [31:0]       i_mem_instr_4,
  input  logic [31:0]       i_mem_instr_5,
  input  logic [31:0]       i_mem_instr_6,
  input  logic [31:0]       i_mem_instr_7,
  input  logic              i_mem_valid,
  output logic [15:0]       o_hit_count,
  output logic [15:0]       o_miss_count
);

  state_e                      r_state;
  state_e                      w_next_state;
  logic [ADDR_W-1:0]           r_miss_addr;
  logic [31:0]                 r_fetch_instr;
  logic                        r_fetch_rdy;
  logic [15:0]                 r_hit_count;
  logic [15:0]                 r_miss_count;

  logic                        w_hit;
  logic [31:0]                 w_hit_word;
  logic                        w_hit_acc;
  logic                        w_miss_acc;
  logic                        w_fill;
  logic [LINE_WORDS-1:0][31:0] w_fill_line;
  logic [WORD_OFF_W-1:0]       w_fill_off;

  assign w_fill_line = {i_mem_instr_7, i_mem_instr_6, i_mem_instr_5, i_mem_instr_4,
                        i_mem_instr_3, i_mem_instr_2, i_mem_instr_1, i_mem_instr_0};
  assign w_fill_off  = r_miss_addr[OFFSET_W-1:2];

  icache_line_store #(
    .NUM_LINES (NUM_LINES),
    .ADDR_W    (ADDR_W)
  ) u_store (
    .i_clk     (i_clk),
    .i_rst     (i_start),
    .i_flush   (i_flush),
    .i_rd_addr (i_fetch_addr),
    .o_hit     (w_hit),
    .o_rd_word (w_hit_word),
    .i_wr_en   (w_fill),
    .i_wr_addr (r_miss_addr),
    .i_wr_line (w_fill_line)
  );

  always_comb begin
    w_next_state = r_state;
    w_hit_acc    = 1'b0;
    w_miss_acc   = 1'b0;
    w_fill       = 1'b0;
    case (r_state)
      LOOKUP: begin
        if (i_fetch_req) begin
          if (w_hit) begin
            w_hit_acc = 1'b1;
          end else begin
            w_miss_acc   = 1'b1;
            w_next_state = REQ;
          end
        end
      end
      REQ:  w_next_state = WAIT;
      WAIT: begin
        if (i_mem_valid) begin
          w_fill       = 1'b1;
          w_next_state = RESP;
        end
      end
      RESP:    w_next_state = LOOKUP;
      default: w_next_state = LOOKUP;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_start) begin
    if (i_start) begin
      r_state       <= LOOKUP;
      r_miss_addr   <= '0;
      r_fetch_instr <= '0;
      r_fetch_rdy   <= 1'b0;
      r_hit_count   <= '0;
      r_miss_count  <= '0;
    end else begin
      r_state     <= w_next_state;
      r_fetch_rdy <= w_hit_acc | w_fill;
      if (w_hit_acc)   r_fetch_instr <= w_hit_word;
      else if (w_fill) r_fetch_instr <= w_fill_line[w_fill_off];
      if (w_miss_acc)  r_miss_addr   <= i_fetch_addr;
      if (w_hit_acc && (r_hit_count != 16'hFFFF))   r_hit_count  <= r_hit_count + 16'd1;
      if (w_miss_acc && (r_miss_count != 16'hFFFF)) r_miss_count <= r_miss_count + 16'd1;
    end
  end

  // mem_addr is derived from the latched miss address, so it stays put
  // from the REQ cycle until the fill returns.
  assign o_mem_addr    = {r_miss_addr[ADDR_W-1:OFFSET_W], OFFSET_W'(0)};
  assign o_mem_read    = (r_state == REQ);
  assign o_stall       = (r_state != LOOKUP) | w_miss_acc;
  assign o_fetch_instr = r_fetch_instr;
  assign o_fetch_rdy   = r_fetch_rdy;
  assign o_hit_count   = r_hit_count;
  assign o_miss_count  = r_miss_count;

endmodule

// File: tb/tb_inst_cache.sv
// Self-checking bench for inst_cache: directed scenarios plus randomized
// fetch traffic compared against a line-residency model.
module tb_inst_cache;

  localparam int NL = 4;

  logic        clk = 1'b0;
  logic        start;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic [31:0] fetch_instr;
  logic        fetch_rdy;
  logic        stall;
  logic        flush;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic [31:0] m_in [8];
  logic        mem_valid;
  logic [15:0] hit_count;
  logic [15:0] miss_count;

  inst_cache #(.NUM_LINES(NL), .ADDR_W(32)) dut (
    .i_clk         (clk),
    .i_start       (start),
    .i_fetch_req   (fetch_req),
    .i_fetch_addr  (fetch_addr),
    .o_fetch_instr (fetch_instr),
    .o_fetch_rdy   (fetch_rdy),
    .o_stall       (stall),
    .i_flush       (flush),
    .o_mem_read    (mem_read),
    .o_mem_addr    (mem_addr),
    .i_mem_instr_0 (m_in[0]),
    .i_mem_instr_1 (m_in[1]),
    .i_mem_instr_2 (m_in[2]),
    .i_mem_instr_3 (m_in[3]),
    .i_mem_instr_4 (m_in[4]),
    .i_mem_instr_5 (m_in[5]),
    .i_mem_instr_6 (m_in[6]),
    .i_mem_instr_7 (m_in[7]),
    .i_mem_valid   (mem_valid),
    .o_hit_count   (hit_count),
    .o_miss_count  (miss_count)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: which aligned line is resident at each index.
  bit          m_valid [NL];
  logic [31:0] m_line  [NL];
  logic [15:0] m_hits;
  logic [15:0] m_misses;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Read-only instruction memory contents.
  function automatic logic [31:0] mem_word(input logic [31:0] line, input int k);
    if (line == 32'h0)  return 32'h1000 + k;
    if (line == 32'h80) return 32'h2000 + k;
    return (line + 32'(4 * k)) ^ 32'h5A5A_0000;
  endfunction

  task automatic m_clear();
    for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
  endtask

  task automatic m_reset();
    m_clear();
    m_hits   = '0;
    m_misses = '0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_counts();
    chk("hit_count", 32'(hit_count), 32'(m_hits));
    chk("miss_count", 32'(miss_count), 32'(m_misses));
  endtask

  // One fetch starting in LOOKUP; on a miss, memory answers lat cycles
  // after the mem_read cycle. flush_mid pulses flush during the wait.
  task automatic fetch(input logic [31:0] a, input int lat, input bit flush_mid);
    logic [31:0] line;
    logic [31:0] expw;
    int          idx;
    bit          hit;
    line = a & ~32'h1F;
    idx  = int'((a >> 5) % NL);
    hit  = m_valid[idx] && (m_line[idx] == line);
    expw = mem_word(line, int'(a[4:2]));
    fetch_req  = 1'b1;
    fetch_addr = a;
    #1;
    chk("stall_at_req", 32'(stall), 32'(!hit));
    step();
    fetch_req  = 1'b0;
    fetch_addr = $urandom;
    if (hit) begin
      m_hits = sat_inc(m_hits);
      chk("hit_rdy", 32'(fetch_rdy), 32'd1);
      chk("hit_instr", fetch_instr, expw);
      chk("hit_no_memread", 32'(mem_read), 32'd0);
    end else begin
      m_misses = sat_inc(m_misses);
      chk("miss_memread", 32'(mem_read), 32'd1);
      chk("miss_memaddr", mem_addr, line);
      chk("miss_rdy_low", 32'(fetch_rdy), 32'd0);
      for (int c = 0; c < lat; c++) begin
        if (flush_mid && c == lat / 2) flush = 1'b1;
        step();
        if (flush) begin
          flush = 1'b0;
          m_clear();
        end
        chk("wait_memread_low", 32'(mem_read), 32'd0);
        chk("wait_addr_held", mem_addr, line);
      end
      for (int k = 0; k < 8; k++) m_in[k] = mem_word(line, k);
      mem_valid = 1'b1;
      step();
      mem_valid = 1'b0;
      for (int k = 0; k < 8; k++) m_in[k] = $urandom;
      m_valid[idx] = 1'b1;
      m_line[idx]  = line;
      chk("fill_rdy", 32'(fetch_rdy), 32'd1);
      chk("fill_instr", fetch_instr, expw);
      chk("resp_stall", 32'(stall), 32'd1);
      step();
      chk("after_resp_rdy", 32'(fetch_rdy), 32'd0);
      chk("after_resp_stall", 32'(stall), 32'd0);
    end
    chk_counts();
  endtask

  task automatic do_flush();
    flush = 1'b1;
    step();
    flush = 1'b0;
    m_clear();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    int          op;
    start      = 1'b1;
    fetch_req  = 1'b0;
    fetch_addr = '0;
    flush      = 1'b0;
    mem_valid  = 1'b0;
    for (int k = 0; k < 8; k++) m_in[k] = '0;
    m_reset();
    step();
    step();
    chk("rst_instr", fetch_instr, 32'h0);
    chk("rst_rdy", 32'(fetch_rdy), 32'd0);
    chk("rst_memread", 32'(mem_read), 32'd0);
    chk("rst_memaddr", mem_addr, 32'h0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk_counts();
    start = 1'b0;
    step();

    // Cold miss, then back-to-back hits in the same line.
    fetch(32'h00, 9, 1'b0);
    fetch(32'h04, 1, 1'b0);
    fetch(32'h1C, 1, 1'b0);
    fetch(32'h0E, 1, 1'b0);
    chk("hits_after_burst", 32'(hit_count), 32'd3);

    // Conflict at index 0.
    fetch(32'h80, 9, 1'b0);
    fetch(32'h00, 9, 1'b0);

    // Flush in LOOKUP after filling lines 0 and 1.
    fetch(32'h20, 5, 1'b0);
    do_flush();
    fetch(32'h00, 3, 1'b0);
    fetch(32'h20, 3, 1'b0);

    // Flush together with a hit still returns the hit.
    fetch_req  = 1'b1;
    fetch_addr = 32'h04;
    flush      = 1'b1;
    step();
    fetch_req = 1'b0;
    flush     = 1'b0;
    m_hits = sat_inc(m_hits);
    m_clear();
    chk("flushhit_rdy", 32'(fetch_rdy), 32'd1);
    chk("flushhit_instr", fetch_instr, 32'h1001);
    fetch(32'h04, 2, 1'b0);

    // Flush during WAIT: the fill still installs.
    fetch(32'h44, 6, 1'b1);
    fetch(32'h48, 1, 1'b0);

    // Stale mem_valid in LOOKUP.
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("stale_rdy", 32'(fetch_rdy), 32'd0);
    chk("stale_stall", 32'(stall), 32'd0);

    // Randomized traffic.
    for (int n = 0; n < 250; n++) begin
      op = int'($urandom_range(0, 11));
      if (op == 0) begin
        do_flush();
      end else if (op == 1) begin
        mem_valid = 1'b1;
        step();
        mem_valid = 1'b0;
        chk("rnd_stale_rdy", 32'(fetch_rdy), 32'd0);
      end else begin
        a = 32'($urandom_range(0, 1023));
        if ($urandom_range(0, 3) == 0) a[31] = 1'b1;
        fetch(a, int'($urandom_range(1, 12)), ($urandom_range(0, 9) == 0));
      end
    end

    // start during WAIT aborts the miss.
    do_flush();
    fetch_req  = 1'b1;
    fetch_addr = 32'h00;
    step();
    fetch_req = 1'b0;
    step();
    step();
    start = 1'b1;
    #1;
    chk("abort_instr", fetch_instr, 32'h0);
    chk("abort_rdy", 32'(fetch_rdy), 32'd0);
    chk("abort_memread", 32'(mem_read), 32'd0);
    chk("abort_memaddr", mem_addr, 32'h0);
    chk("abort_stall", 32'(stall), 32'd0);
    chk("abort_miss_cnt", 32'(miss_count), 32'd0);
    step();
    start = 1'b0;
    m_reset();
    step();
    for (int k = 0; k < 8; k++) m_in[k] = mem_word(32'h0, k);
    mem_valid = 1'b1;
    step();
    mem_valid = 1'b0;
    chk("abort_stale_rdy", 32'(fetch_rdy), 32'd0);
    chk("abort_stale_stall", 32'(stall), 32'd0);
    step();
    chk("abort_stale_rdy2", 32'(fetch_rdy), 32'd0);
    fetch(32'h00, 9, 1'b0);

    // Hit counter saturation.
    fetch_req  = 1'b1;
    fetch_addr = 32'h08;
    while (m_hits != 16'hFFFE) begin
      step();
      m_hits = sat_inc(m_hits);
    end
    fetch_req = 1'b0;
    chk("sat_preload", 32'(hit_count), 32'h0000_FFFE);
    chk("sat_preload_instr", fetch_instr, 32'h1002);
    fetch(32'h00, 1, 1'b0);
    fetch(32'h10, 1, 1'b0);
    fetch(32'h14, 1, 1'b0);
    chk("sat_final", 32'(hit_count), 32'h0000_FFFF);
    step();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
